// File: rtl/calc_seq.sv
// calc_seq: operation sequencer for the calculator datapath.
// Reads two operands from the 4-entry register file (rsel/q), runs one ALU
// operation and writes the result back (d/wsel/we), reporting done and flags.
// Optional feature macro: SEQ_MUL_EN enables op 111 as an iterative
// shift-add multiplier (EXE lasts WIDTH cycles); when undefined, op 111 is
// treated as unsupported and no multiplier logic is built.
module calc_seq #(
  parameter int WIDTH = 16,
  parameter int SELW  = 2
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SELW-1:0]  src_a,
  input  logic [SELW-1:0]  src_b,
  input  logic [SELW-1:0]  dst,
  input  logic [WIDTH-1:0] q,
  output logic [SELW-1:0]  rsel,
  output logic [SELW-1:0]  wsel,
  output logic [WIDTH-1:0] d,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXE  = 3'd3,
    WRB  = 3'd4
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [SELW-1:0]  srcb_r;
  logic [SELW-1:0]  dst_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_ok_s;
  logic [WIDTH-1:0] exe_res_s;
  logic             exe_carry_s;
  logic             exe_ok_s;
  logic             exe_last_s;

`ifdef SEQ_MUL_EN
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  // {high accumulator, low multiplier}: each EXE cycle consumes one multiplier bit
  logic [2*WIDTH-1:0] prod_r;
  logic [CNTW-1:0]    cnt_r;
  logic [WIDTH:0]     mstep_s;
  logic [2*WIDTH-1:0] mnext_s;
`endif

  // Result, carry and completion of the EXE step for the operation in flight
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ok_s    = 1'b1;
    case (op_r)
      3'b000: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
      end
      3'b001: begin
        alu_res_s   = a_r - b_r;
        alu_carry_s = (a_r < b_r);
      end
      3'b010: alu_res_s = a_r & b_r;
      3'b011: alu_res_s = a_r | b_r;
      3'b100: alu_res_s = a_r ^ b_r;
      3'b101: {alu_carry_s, alu_res_s} = {a_r, 1'b0};
      3'b110: {alu_res_s, alu_carry_s} = {1'b0, a_r};
      default: alu_ok_s = 1'b0;
    endcase

    exe_res_s   = alu_res_s;
    exe_carry_s = alu_carry_s;
    exe_ok_s    = alu_ok_s;
    exe_last_s  = 1'b1;

`ifdef SEQ_MUL_EN
    mstep_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
            + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    mnext_s = {mstep_s, prod_r[WIDTH-1:1]};
    if (op_r == 3'b111) begin
      exe_res_s   = mnext_s[WIDTH-1:0];
      exe_carry_s = |mnext_s[2*WIDTH-1:WIDTH];
      exe_ok_s    = 1'b1;
      exe_last_s  = (cnt_r == LAST_BIT);
    end else begin
      exe_last_s  = 1'b1;
    end
`endif
  end

  // Sequencer FSM with all outputs registered; reset aborts any operation at once
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      srcb_r  <= {SELW{1'b0}};
      dst_r   <= {SELW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      rsel    <= {SELW{1'b0}};
      wsel    <= {SELW{1'b0}};
      d       <= {WIDTH{1'b0}};
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      err     <= 1'b0;
`ifdef SEQ_MUL_EN
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CNTW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            srcb_r  <= src_b;
            dst_r   <= dst;
            rsel    <= src_a;
            err     <= 1'b0;
            busy    <= 1'b1;
            state_r <= RDA;
          end else begin
            state_r <= IDLE;
          end
        end
        RDA: begin
          a_r     <= q;
          rsel    <= srcb_r;
          state_r <= RDB;
        end
        RDB: begin
          b_r     <= q;
`ifdef SEQ_MUL_EN
          prod_r  <= {{WIDTH{1'b0}}, q};
          cnt_r   <= {CNTW{1'b0}};
`endif
          state_r <= EXE;
        end
        EXE: begin
`ifdef SEQ_MUL_EN
          prod_r <= mnext_s;
          cnt_r  <= cnt_r + CNTW'(1'b1);
`endif
          if (exe_last_s) begin
            if (exe_ok_s) begin
              d     <= exe_res_s;
              carry <= exe_carry_s;
              zero  <= (exe_res_s == {WIDTH{1'b0}});
              we    <= 1'b1;
            end else begin
              err   <= 1'b1;
              we    <= 1'b0;
            end
            wsel    <= dst_r;
            done    <= 1'b1;
            state_r <= WRB;
          end else begin
            state_r <= EXE;
          end
        end
        WRB: begin
          we      <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          we      <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: register-file environment, queue scoreboard and an
// arithmetic reference model of each operation. Honours SEQ_MUL_EN.
module tb_calc_seq;
  localparam int W = 16;
  localparam int S = 2;

  logic         ck = 1'b0;
  logic         res = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [S-1:0] src_a = '0, src_b = '0, dst = '0;
  logic [W-1:0] q;
  logic [S-1:0] rsel, wsel;
  logic [W-1:0] d;
  logic         we, busy, done, carry, zero, err;

  calc_seq #(.WIDTH(W), .SELW(S)) dut (
    .ck(ck), .res(res), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst(dst), .q(q), .rsel(rsel), .wsel(wsel), .d(d), .we(we), .busy(busy),
    .done(done), .carry(carry), .zero(zero), .err(err)
  );

  always #5 ck = ~ck;

  // environment register file (combinational read, write on rising edge)
  logic [W-1:0] rf [4];
  logic [W-1:0] pl_val [4];
  logic         pl_en = 1'b0;
  assign q = rf[rsel];
  always @(posedge ck) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= pl_val[i];
    end else if (res && we) begin
      rf[wsel] <= d;
    end
  end

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    int           cycle;
    int           busy_len;
    logic         we;
    logic [S-1:0] wsel;
    logic [W-1:0] d;
    logic         carry;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state
  logic [W-1:0] mrf [4];
  logic [W-1:0] m_d = '0;
  logic         m_carry = 1'b0, m_zero = 1'b0;
  int           free_edge = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Behavioural model: accept a request at rising edge e
  task automatic model_accept(input int e, input int o, input int a, input int b, input int dd);
    exp_t   x;
    longint av, bv, r;
    longint m;
    bit     ok, c, is_mul;
    m = 64'd1 << W;
    av = longint'(mrf[a]);
    bv = longint'(mrf[b]);
    ok = 1'b1; c = 1'b0; is_mul = 1'b0; r = 0;
    case (o)
      0: begin r = av + bv; c = (r >= m); end
      1: begin c = (av < bv); r = av - bv + (c ? m : 64'd0); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = av * 2; c = (av >= m / 2); end
      6: begin r = av / 2; c = (av % 2) == 1; end
      7: begin
`ifdef SEQ_MUL_EN
        r = av * bv; c = (r >= m); is_mul = 1'b1;
`else
        ok = 1'b0;
`endif
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      m_d     = W'(r % m);
      m_carry = c;
      m_zero  = (m_d == '0);
      mrf[dd] = m_d;
    end
    x.cycle    = e + 3 + (is_mul ? W - 1 : 0);
    x.busy_len = is_mul ? W + 3 : 4;
    x.we       = ok;
    x.wsel     = S'(dd);
    x.d        = m_d;
    x.carry    = m_carry;
    x.zero     = m_zero;
    x.err      = !ok;
    free_edge  = e + x.busy_len + 1;
    exp_q.push_back(x);
  endtask

  // one cycle of stimulus, presented at the falling edge
  task automatic drive(input bit st, input int o, input int a, input int b, input int dd);
    @(negedge ck);
    start = st; op = 3'(o); src_a = S'(a); src_b = S'(b); dst = S'(dd);
    if (st && (cyc + 1) >= free_edge) model_accept(cyc + 1, o, a, b, dd);
  endtask

  task automatic idle_cycle();
    drive(1'b0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic issue(input int o, input int a, input int b, input int dd);
    int n = 0;
    while ((cyc + 1) < free_edge && n < 100) begin idle_cycle(); n++; end
    drive(1'b1, o, a, b, dd);
    drive(1'b0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin @(negedge ck); n++; end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic preload(input logic [W-1:0] v0, v1, v2, v3);
    drain();
    @(negedge ck);
    start = 1'b0;
    pl_val[0] = v0; pl_val[1] = v1; pl_val[2] = v2; pl_val[3] = v3;
    for (int i = 0; i < 4; i++) mrf[i] = pl_val[i];
    pl_en = 1'b1;
    @(negedge ck);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, we, 0);     chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0); chk({tag, "_rsel"}, rsel, 0);
    chk({tag, "_wsel"}, wsel, 0); chk({tag, "_d"}, d, 0);
    chk({tag, "_carry"}, carry, 0); chk({tag, "_zero"}, zero, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // reset in the middle of an op: steps = falling edges after acceptance
  task automatic abort_after(input int steps, input string tag);
    logic [W-1:0] old;
    old = rf[3];
    drive(1'b1, 0, 0, 1, 3);
    for (int i = 0; i < steps; i++) drive(1'b0, 0, 0, 0, 0);
    #2 res = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs(tag);
    @(posedge ck); #1;
    chk({tag, "_no_write"}, rf[3], old);
    @(negedge ck); #2 res = 1'b1;
    m_d = '0; m_carry = 1'b0; m_zero = 1'b0; free_edge = 0;
  endtask

  // scoreboard monitor: compares every completion against the queue head
  int   busy_run = 0;
  exp_t mx;
  always @(negedge ck) begin
    if (!res) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++; else busy_run = 0;
      if (we) chk("we_outside_wrb", done, 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
        end else begin
          mx = exp_q.pop_front();
          chk("latency", cyc, mx.cycle);
          chk("busy_len", busy_run, mx.busy_len);
          chk("we", we, mx.we);
          chk("wsel", wsel, mx.wsel);
          chk("d", d, mx.d);
          chk("carry", carry, mx.carry);
          chk("zero", zero, mx.zero);
          chk("err", err, mx.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin pl_val[i] = '0; mrf[i] = '0; end
    res = 1'b0;
    repeat (3) @(negedge ck);
    check_reset_outputs("reset");
    #2 res = 1'b1;

    // ADD basic
    preload(16'h4c55, 16'h0001, 16'h0000, 16'h0000);
    issue(0, 0, 1, 2);
    // ADD wrap to zero, then SUB with borrow
    preload(16'hffff, 16'h0001, 16'h0001, 16'h0002);
    issue(0, 0, 1, 1);
    issue(1, 2, 3, 0);
    // shifts and XOR of equal operands
    preload(16'h8001, 16'h0003, 16'h4c55, 16'h0000);
    issue(5, 0, 1, 3);
    issue(6, 1, 0, 3);
    issue(4, 2, 2, 3);
    drain();

    // start held high with changing op/dst across the whole operation
    for (int i = 0; i < 12; i++)
      drive(1'b1, $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    drive(1'b0, 0, 0, 0, 0);
    drain();

    // reset during RDB and during WRB
    preload(16'h1234, 16'h1111, 16'h0000, 16'h5a5a);
    abort_after(2, "abort_rdb");
    preload(16'h1234, 16'h1111, 16'h0000, 16'h5a5a);
    abort_after(4, "abort_wrb");
    preload(16'h1234, 16'h1111, 16'h0000, 16'h5a5a);
    issue(0, 0, 1, 3);
    drain();

    // op 111: first leave nonzero flags, then request the multiply
    preload(16'h0100, 16'h0100, 16'hffff, 16'h0001);
    issue(0, 2, 3, 2);
    issue(7, 0, 1, 3);
    drain();

    // randomized traffic, including requests while busy
    preload(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
    drive(1'b0, 0, 0, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) chk("rf_final", rf[i], mrf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
